// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the uart transmit scheduler: FSM encoding, id width
// and the counter width helper.
package uart_tx_sched_pkg;

  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_SENDING = 2'd2,
    ST_NEXT    = 2'd3
  } state_t;

  // Bits needed to hold the value itself (never less than 1).
  function automatic int get_width(input int value);
    int w;
    w = 1;
    while ((2 ** w) <= value) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Client request bus plus uart-side strobe for the transmit scheduler.
interface uart_tx_sched_if import uart_tx_sched_pkg::*; #(
  parameter int NUM_REQ = 4
) ();

  // Handshake: a client holds req_valid/req_data/req_last stable until its
  // req_ready bit pulses for one cycle, which means the uart took that byte;
  // the next byte may be presented from the following cycle. uart_we and
  // uart_data stay stable until uart_tx_busy is observed high.
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 err_timeout;
  logic                 uart_we;
  logic [7:0]           uart_data;
  logic                 uart_tx_busy;
  state_t               dbg_state;

  modport master (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, grant_id, busy, err_timeout, uart_we, uart_data, dbg_state
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, grant_id, busy, err_timeout, uart_we, uart_data, dbg_state
  );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module uart_tx_sched_rr_arbiter import uart_tx_sched_pkg::*; #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;

  always_comb begin
    // Rotate so bit 0 is the pointer position, then take the lowest set bit.
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (ID_W + 1)'(NUM_REQ)) sum = sum - (ID_W + 1)'(NUM_REQ);
    gnt_idx = sum[ID_W-1:0];
    any     = |req;
    gnt     = any ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart transmitter among byte-stream clients;
// grants whole messages or at most MAX_BURST bytes before rotating.
module uart_tx_sched import uart_tx_sched_pkg::*; #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 16,
  parameter int ISSUE_TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_sched_if.slave  bus
);

  localparam int WAIT_W = get_width(ISSUE_TIMEOUT);

  state_t             state, state_n;
  logic [ID_W-1:0]    grant_id, grant_n;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_n;
  logic               busy_r, busy_n;
  logic               we_r, we_n;
  logic               err_r, err_n;
  logic               last_seen, last_seen_n;
  logic [7:0]         data_r, data_n;
  logic [7:0]         burst_cnt, burst_n;
  logic [NUM_REQ-1:0] ready_r, ready_n;
  logic [WAIT_W-1:0]  wait_cnt, wait_n;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [7:0]         pick_data;
  logic               own_valid;
  logic               own_last;
  logic [7:0]         own_data;
  logic               burst_done;

  uart_tx_sched_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (pick_onehot),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    pick_data = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_data = bus.req_data[8*i +: 8];
      if (grant_id == ID_W'(i)) begin
        own_valid = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  assign burst_done = (burst_cnt == 8'(MAX_BURST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      busy_r    <= 1'b0;
      we_r      <= 1'b0;
      err_r     <= 1'b0;
      last_seen <= 1'b0;
      data_r    <= '0;
      burst_cnt <= '0;
      ready_r   <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_n;
      grant_id  <= grant_n;
      rr_ptr    <= rr_ptr_n;
      busy_r    <= busy_n;
      we_r      <= we_n;
      err_r     <= err_n;
      last_seen <= last_seen_n;
      data_r    <= data_n;
      burst_cnt <= burst_n;
      ready_r   <= ready_n;
      wait_cnt  <= wait_n;
    end
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant_id;
    rr_ptr_n    = rr_ptr;
    busy_n      = busy_r;
    we_n        = we_r;
    err_n       = 1'b0;
    last_seen_n = last_seen;
    data_n      = data_r;
    burst_n     = burst_cnt;
    ready_n     = '0;
    wait_n      = wait_cnt;

    unique case (state)
      ST_IDLE: begin
        if (pick_any && !bus.uart_tx_busy) begin
          grant_n = pick_idx;
          busy_n  = 1'b1;
          burst_n = '0;
          data_n  = pick_data;
          we_n    = 1'b1;
          wait_n  = '0;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.uart_tx_busy) begin
          ready_n     = NUM_REQ'(1) << grant_id;
          we_n        = 1'b0;
          burst_n     = burst_done ? burst_cnt : burst_cnt + 8'd1;
          last_seen_n = own_last;
          state_n     = ST_SENDING;
        end else if (wait_cnt == WAIT_W'(ISSUE_TIMEOUT - 1)) begin
          // The byte is abandoned: no ready pulse, ownership rotates away.
          err_n   = 1'b1;
          we_n    = 1'b0;
          state_n = ST_NEXT;
        end else begin
          wait_n = wait_cnt + WAIT_W'(1);
        end
      end
      ST_SENDING: begin
        // A stalled owner keeps the grant until it supplies the rest of its message.
        if (!bus.uart_tx_busy) begin
          if (last_seen || burst_done) begin
            state_n = ST_NEXT;
          end else if (own_valid) begin
            data_n  = own_data;
            we_n    = 1'b1;
            wait_n  = '0;
            state_n = ST_ISSUE;
          end
        end
      end
      ST_NEXT: begin
        rr_ptr_n = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        busy_n   = 1'b0;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.req_ready   = ready_r;
  assign bus.grant_id    = grant_id;
  assign bus.busy        = busy_r;
  assign bus.err_timeout = err_r;
  assign bus.uart_we     = we_r;
  assign bus.uart_data   = data_r;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural uart and a
// message-level round-robin model feeding an expected (owner, byte) queue.
module tb_uart_tx_sched import uart_tx_sched_pkg::*;;

  localparam int N     = 4;
  localparam int MB    = 2;
  localparam int TO    = 32;
  localparam int FRAME = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_sched_if #(.NUM_REQ(N)) bus ();

  uart_tx_sched #(.NUM_REQ(N), .MAX_BURST(MB), .ISSUE_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural uart ----------------
  logic       u_busy;
  int         u_cnt;
  bit         uart_dead = 1'b0;
  logic [7:0] uart_log[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      u_busy <= 1'b0;
      u_cnt  <= 0;
    end else if (!u_busy) begin
      if (bus.uart_we && !uart_dead) begin
        u_busy <= 1'b1;
        u_cnt  <= 0;
        uart_log.push_back(bus.uart_data);
      end
    end else begin
      if (u_cnt == FRAME - 1) u_busy <= 1'b0;
      u_cnt <= u_cnt + 1;
    end
  end

  assign bus.uart_tx_busy = u_busy;

  // ---------------- bench state ----------------
  logic [8:0]  dq [N][$];   // bytes the client drivers present ({last, data})
  logic [8:0]  mq [N][$];   // bytes the model schedules
  logic [10:0] exp_q[$];    // expected {owner, byte} per accepted byte
  int          m_ptr;
  int          n_checks;
  int          n_errors;
  int          cyc;
  int          ready_cnt [N];
  logic        prev_txb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (dq[i].size() > 0) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_data[8*i +: 8]  = dq[i][0][7:0];
        bus.req_last[i]         = dq[i][0][8];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_data[8*i +: 8]  = 8'h00;
        bus.req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic load_drv(input int c, input logic [7:0] b, input logic l);
    dq[c].push_back({l, b});
  endtask

  task automatic load_model(input int c, input logic [7:0] b, input logic l);
    mq[c].push_back({l, b});
  endtask

  task automatic load(input int c, input logic [7:0] b, input logic l);
    load_drv(c, b, l);
    load_model(c, b, l);
  endtask

  function automatic bit queues_empty(input bit model);
    for (int i = 0; i < N; i++) begin
      if (model && mq[i].size() > 0) return 1'b0;
      if (!model && dq[i].size() > 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Message-level scheduling: owner = first client with data from the
  // pointer; it sends until its last byte or MB bytes; pointer = owner + 1.
  task automatic model_run();
    int         c;
    int         sent;
    logic [8:0] e;
    bit         more;
    while (!queues_empty(1'b1)) begin
      c = m_ptr;
      while (mq[c].size() == 0) c = (c + 1) % N;
      sent = 0;
      more = 1'b1;
      while (more) begin
        e = mq[c].pop_front();
        exp_q.push_back({3'(c), e[7:0]});
        sent++;
        more = !e[8] && (sent < MB) && (mq[c].size() > 0);
      end
      m_ptr = (c + 1) % N;
    end
  endtask

  // One cycle: sample at the falling edge, score, then update client drivers.
  task automatic tick();
    logic [10:0] e;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (bus.req_ready != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'(bus.req_ready), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ready_owner", 32'(bus.req_ready), 32'(4'b0001 << e[10:8]));
          check("grant_id", 32'(bus.grant_id), 32'(e[10:8]));
          check("tx_byte", 32'(bus.uart_data), 32'(e[7:0]));
          check("busy_on_ready", 32'(bus.busy), 32'd1);
        end
        for (int i = 0; i < N; i++) begin
          if (bus.req_ready[i]) begin
            ready_cnt[i]++;
            if (dq[i].size() > 0) void'(dq[i].pop_front());
          end
        end
      end
      if (bus.uart_we) check("we_while_tx_busy", 32'(u_busy && prev_txb), 32'd0);
      if (bus.err_timeout && dq[bus.grant_id].size() > 0) void'(dq[bus.grant_id].pop_front());
    end
    prev_txb = u_busy;
    drive_reqs();
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !(queues_empty(1'b0) && !bus.busy && !u_busy)) begin
      tick();
      k++;
    end
    check({name, "_done_in_time"}, 32'(k < budget), 32'd1);
    tick();
    tick();
    check({name, "_exp_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset(input string name);
    check({name, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    check({name, "_grant_id"}, 32'(bus.grant_id), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_err_timeout"}, 32'(bus.err_timeout), 32'd0);
    check({name, "_uart_we"}, 32'(bus.uart_we), 32'd0);
    check({name, "_uart_data"}, 32'(bus.uart_data), 32'd0);
    check({name, "_state"}, 32'(bus.dbg_state), 32'(ST_IDLE));
  endtask

  task automatic wait_ready(input string name, input int c, input int budget);
    int k;
    k = 0;
    while (k < budget && !bus.req_ready[c]) begin
      tick();
      k++;
    end
    check({name, "_ready_seen"}, 32'(bus.req_ready[c]), 32'd1);
  endtask

  initial begin
    int k;
    int c0;
    int rc;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    m_ptr    = 0;
    prev_txb = 1'b0;
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;

    // ---- reset values ----
    rst = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // ---- single client, two-byte message ----
    load(0, 8'h55, 1'b0);
    load(0, 8'hA3, 1'b1);
    model_run();
    check("s1_model_len", 32'(exp_q.size()), 32'd2);
    check("s1_model_first", 32'(exp_q[0]), 32'({3'd0, 8'h55}));
    drive_reqs();
    wait_done("s1", 200);
    check("s1_uart_count", 32'(uart_log.size()), 32'd2);
    if (uart_log.size() == 2) begin
      check("s1_uart_byte0", 32'(uart_log[0]), 32'h55);
      check("s1_uart_byte1", 32'(uart_log[1]), 32'hA3);
    end
    check("s1_ready0_pulses", 32'(ready_cnt[0]), 32'd2);
    check("s1_busy_after", 32'(bus.busy), 32'd0);

    // ---- clients 1 and 3, one-byte messages, twice each ----
    load(1, 8'h11, 1'b1);
    load(1, 8'h12, 1'b1);
    load(3, 8'h33, 1'b1);
    load(3, 8'h34, 1'b1);
    model_run();
    check("s2_model_second", 32'(exp_q[1]), 32'({3'd3, 8'h33}));
    check("s2_model_third", 32'(exp_q[2]), 32'({3'd1, 8'h12}));
    drive_reqs();
    wait_done("s2", 400);

    // ---- uart never goes busy: timeout, no ready, pointer moves past 0 ----
    uart_dead = 1'b1;
    rc = ready_cnt[0];
    load_drv(0, 8'hEE, 1'b1);
    drive_reqs();
    k = 0;
    while (k < 50 && !bus.uart_we) begin
      tick();
      k++;
    end
    check("to_we_rise", 32'(bus.uart_we), 32'd1);
    c0 = cyc;
    k = 0;
    while (k < 100 && !bus.err_timeout) begin
      tick();
      k++;
    end
    check("to_latency", 32'(cyc - c0), 32'd32);
    check("to_we_dropped", 32'(bus.uart_we), 32'd0);
    tick();
    check("to_pulse_width", 32'(bus.err_timeout), 32'd0);
    wait_done("to", 100);
    check("to_no_ready", 32'(ready_cnt[0]), 32'(rc));
    uart_dead = 1'b0;
    m_ptr = 1;

    // ---- burst limit: client 2 five bytes, client 0 one message ----
    load(2, 8'h21, 1'b0);
    load(2, 8'h22, 1'b0);
    load(2, 8'h23, 1'b0);
    load(2, 8'h24, 1'b0);
    load(2, 8'h25, 1'b1);
    load(0, 8'h0C, 1'b1);
    model_run();
    check("s3_model_len", 32'(exp_q.size()), 32'd6);
    check("s3_model_third", 32'(exp_q[2]), 32'({3'd0, 8'h0C}));
    drive_reqs();
    wait_done("s3", 600);

    // ---- owner 1 stalls mid-message while client 0 waits ----
    load_model(1, 8'hA1, 1'b0);
    load_model(1, 8'hB2, 1'b1);
    model_run();
    load_drv(1, 8'hA1, 1'b0);
    drive_reqs();
    wait_ready("s4", 1, 100);
    load(0, 8'hC0, 1'b1);
    model_run();
    drive_reqs();
    for (int i = 0; i < 100; i++) begin
      tick();
      check("s4_no_ready", 32'(bus.req_ready), 32'd0);
      check("s4_no_we", 32'(bus.uart_we), 32'd0);
      check("s4_busy", 32'(bus.busy), 32'd1);
      check("s4_owner", 32'(bus.grant_id), 32'd1);
    end
    check("s4_uart_idle", 32'(u_busy), 32'd0);
    load_drv(1, 8'hB2, 1'b1);
    drive_reqs();
    wait_done("s4", 300);

    // ---- reset while a byte is on the wire ----
    load(2, 8'hF0, 1'b1);
    model_run();
    drive_reqs();
    wait_ready("s6", 2, 100);
    repeat (3) tick();
    check("s6_sending", 32'(bus.dbg_state), 32'(ST_SENDING));
    rst = 1'b1;
    tick();
    check_reset("s6_rst");
    check("s6_uart_reset", 32'(u_busy), 32'd0);
    rst = 1'b0;
    tick();
    m_ptr = 0;
    load(3, 8'hC3, 1'b1);
    load(0, 8'h5A, 1'b1);
    model_run();
    check("s6_model_first", 32'(exp_q[0]), 32'({3'd0, 8'h5A}));
    drive_reqs();
    wait_done("s6", 300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
